// File: rtl/mem_sequencer_if.sv
// mem_sequencer_if: request, response and RAM-side wiring of the shared-RAM sequencer.
// Latency: none, this is pure wiring. master = the sequencer; slave = requesters plus RAM.
// Backpressure: requesters hold their request level and watch busy; there is no ready.
interface mem_sequencer_if #(
    parameter int ADDR_W = 32
);
    // requests
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              flush;
    logic              data_req;
    logic              data_we;
    logic [2:0]        data_funct3;
    logic [ADDR_W-1:0] data_addr;
    logic [31:0]       data_wdata;
    // RAM port
    logic              ram_en;
    logic              ram_we;
    logic [3:0]        ram_be;
    logic [ADDR_W-3:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;
    // responses
    logic [31:0]       inst;
    logic              inst_valid;
    logic [31:0]       load_data;
    logic              data_done;
    logic              misalign;
    logic              busy;

    modport master (
        input  fetch_req, fetch_addr, flush, data_req, data_we, data_funct3,
               data_addr, data_wdata, ram_rdata,
        output ram_en, ram_we, ram_be, ram_addr, ram_wdata,
               inst, inst_valid, load_data, data_done, misalign, busy
    );

    modport slave (
        output fetch_req, fetch_addr, flush, data_req, data_we, data_funct3,
               data_addr, data_wdata, ram_rdata,
        input  ram_en, ram_we, ram_be, ram_addr, ram_wdata,
               inst, inst_valid, load_data, data_done, misalign, busy
    );
endinterface

// File: rtl/mem_sequencer.sv
// mem_sequencer: shares one single-port RAM between instruction fetch and load/store.
// Latency: fetch/load pulse 2+RAM_LAT cycles after the accepting IDLE cycle; store done after 2.
// Backpressure: busy is high outside IDLE; requests are sampled only in IDLE, data before fetch.
// Ports: clk, reset (sync, active high), bus (mem_sequencer_if.master: requests, RAM port, responses).
module mem_sequencer #(
    parameter int RAM_LAT = 1,
    parameter int ADDR_W  = 32
) (
    input  logic            clk,
    input  logic            reset,
    mem_sequencer_if.master bus
);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, STORE, RESP} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic [2:0]        funct3_q;
    logic [31:0]       wdata_q;
    logic              is_fetch_q;
    logic [2:0]        cnt_q;
    logic              misalign_q;
    logic [31:0]       inst_q;
    logic [31:0]       load_q;

    logic              data_mis;
    logic              fetch_drop;
    logic [7:0]        rd_byte;
    logic [15:0]       rd_half;
    logic [31:0]       load_ext;
    logic [3:0]        st_be;
    logic [31:0]       st_wdata;

    // Undefined width codes fall into the word rule.
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
        case (f3)
            3'b000, 3'b100: misaligned = 1'b0;
            3'b001, 3'b101: misaligned = a[0];
            default:        misaligned = (a != 2'b00);
        endcase
    endfunction

    assign data_mis   = misaligned(bus.data_funct3, bus.data_addr[1:0]);
    // Only meaningful in ISSUE/WAIT/RESP; a flush never touches a data access.
    assign fetch_drop = is_fetch_q && bus.flush;

    // Load lane selection and extension.
    always_comb begin
        rd_byte  = 8'(bus.ram_rdata >> {addr_q[1:0], 3'b000});
        rd_half  = 16'(bus.ram_rdata >> {addr_q[1], 4'b0000});
        load_ext = bus.ram_rdata;
        case (funct3_q)
            3'b000:  load_ext = {{24{rd_byte[7]}}, rd_byte};
            3'b100:  load_ext = {24'h0, rd_byte};
            3'b001:  load_ext = {{16{rd_half[15]}}, rd_half};
            3'b101:  load_ext = {16'h0, rd_half};
            default: load_ext = bus.ram_rdata;
        endcase
    end

    // Store lanes: narrow data is replicated so the RAM only needs the byte enables.
    always_comb begin
        st_be    = 4'b1111;
        st_wdata = wdata_q;
        case (funct3_q)
            3'b000: begin
                st_be    = 4'b0001 << addr_q[1:0];
                st_wdata = {4{wdata_q[7:0]}};
            end
            3'b001: begin
                st_be    = 4'b0011 << addr_q[1:0];
                st_wdata = {2{wdata_q[15:0]}};
            end
            default: begin
                st_be    = 4'b1111;
                st_wdata = wdata_q;
            end
        endcase
    end

    // Next state and state-decoded outputs; RAM port is zero whenever it is not strobed.
    always_comb begin
        state_nxt      = state;
        bus.ram_en     = 1'b0;
        bus.ram_we     = 1'b0;
        bus.ram_be     = 4'b0000;
        bus.ram_addr   = '0;
        bus.ram_wdata  = 32'h0;
        bus.inst_valid = 1'b0;
        bus.data_done  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.data_req) begin
                    if (!data_mis) state_nxt = bus.data_we ? STORE : ISSUE;
                end else if (bus.fetch_req) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                bus.ram_en   = 1'b1;
                bus.ram_addr = addr_q[ADDR_W-1:2];
                state_nxt    = fetch_drop ? IDLE : WAIT;
            end
            WAIT: begin
                if (fetch_drop)        state_nxt = IDLE;
                else if (cnt_q == 3'd0) state_nxt = RESP;
            end
            STORE: begin
                bus.ram_en    = 1'b1;
                bus.ram_we    = 1'b1;
                bus.ram_be    = st_be;
                bus.ram_addr  = addr_q[ADDR_W-1:2];
                bus.ram_wdata = st_wdata;
                state_nxt     = RESP;
            end
            RESP: begin
                bus.inst_valid = is_fetch_q && !bus.flush;
                bus.data_done  = !is_fetch_q;
                state_nxt      = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            addr_q     <= '0;
            funct3_q   <= 3'b000;
            wdata_q    <= 32'h0;
            is_fetch_q <= 1'b0;
            cnt_q      <= 3'd0;
            misalign_q <= 1'b0;
            inst_q     <= 32'h0;
            load_q     <= 32'h0;
        end else begin
            state      <= state_nxt;
            misalign_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.data_req) begin
                        addr_q     <= bus.data_addr;
                        funct3_q   <= bus.data_funct3;
                        wdata_q    <= bus.data_wdata;
                        is_fetch_q <= 1'b0;
                        misalign_q <= data_mis;
                    end else if (bus.fetch_req) begin
                        addr_q     <= bus.fetch_addr;
                        is_fetch_q <= 1'b1;
                    end
                end
                // Counter restarts on every issue, so a read left over from a
                // dropped fetch can never line up with the capture point.
                ISSUE: cnt_q <= 3'(RAM_LAT - 1);
                WAIT: begin
                    if (cnt_q != 3'd0) begin
                        cnt_q <= cnt_q - 3'd1;
                    end else if (!fetch_drop) begin
                        if (is_fetch_q) inst_q <= bus.ram_rdata;
                        else            load_q <= load_ext;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy      = (state != IDLE);
    assign bus.misalign  = misalign_q;
    assign bus.inst      = inst_q;
    assign bus.load_data = load_q;
endmodule
